// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - baud-rate table, rate codes and phase-increment calculation for the UART baud generator
package uart_pkg;

   typedef enum logic [2:0] {
      BAUD_300    = 3'd0,
      BAUD_1200   = 3'd1,
      BAUD_4800   = 3'd2,
      BAUD_9600   = 3'd3,
      BAUD_19200  = 3'd4,
      BAUD_38400  = 3'd5,
      BAUD_57600  = 3'd6,
      BAUD_115200 = 3'd7
   } baud_code_e;

   localparam int unsigned N_BAUD = 8;

   localparam logic [31:0] BAUD_TABLE [N_BAUD] = '{
      32'd300, 32'd1200, 32'd4800, 32'd9600,
      32'd19200, 32'd38400, 32'd57600, 32'd115200
   };

   // round(baud * oversample * 2^acc_w / clk_hz); the 64-bit product stays exact for any legal setup
   function automatic logic [63:0] calc_inc(input logic [31:0] baud,
                                            input int unsigned oversample,
                                            input int unsigned acc_w,
                                            input int unsigned clk_hz);
      logic [63:0] num;
      num = (64'(baud) * 64'(oversample)) << acc_w;
      return (num + 64'(clk_hz / 2)) / 64'(clk_hz);
   endfunction

endpackage

// File: rtl/uart_tick_div.sv
// rtl/uart_tick_div.sv - mod-OVERSAMPLE sample-index counter with clear, load and registered wrap pulse
module uart_tick_div #(
   parameter  int unsigned OVERSAMPLE = 16,
   localparam int unsigned PH_W       = $clog2(OVERSAMPLE)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            load_i,
   input  logic [PH_W-1:0] load_val_i,
   input  logic            step_i,
   output logic [PH_W-1:0] phase_o,
   output logic            wrap_o
);

   localparam logic [PH_W-1:0] LAST = PH_W'(OVERSAMPLE - 1);

   logic [PH_W-1:0] phase_q, phase_d;
   logic            wrap_q, wrap_d;

   always_comb begin
      phase_d = phase_q;
      wrap_d  = 1'b0;
      if (clear_i) begin
         phase_d = '0;
      end else if (load_i) begin
         phase_d = load_val_i;
      end else if (step_i) begin
         if (phase_q == LAST) begin
            phase_d = '0;
            wrap_d  = 1'b1;
         end else begin
            phase_d = phase_q + PH_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         wrap_q  <= wrap_d;
      end
   end

   assign phase_o = phase_q;
   assign wrap_o  = wrap_q;

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - fractional phase-accumulator UART baud generator with oversample and bit ticks
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter  int unsigned CLK_HZ     = 50000000,
   parameter  int unsigned OVERSAMPLE = 16,
   parameter  int unsigned ACC_W      = 24,
   localparam int unsigned PH_W       = $clog2(OVERSAMPLE)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic [2:0]      baud_select,
   input  logic            resync,
   output logic            sample_ENABLE,
   output logic            bit_tick,
   output logic [PH_W-1:0] bit_phase
);

   if (OVERSAMPLE < 4 || OVERSAMPLE > 32) begin : g_bad_os
      $error("uart_baud_gen: OVERSAMPLE must lie in 4..32");
   end

   logic [ACC_W-1:0] inc_tab [N_BAUD];

   for (genvar g = 0; g < N_BAUD; g++) begin : g_inc
      localparam logic [63:0] INC = calc_inc(BAUD_TABLE[g], OVERSAMPLE, ACC_W, CLK_HZ);
      if (INC == 64'd0 || INC >= (64'd1 << ACC_W)) begin : g_bad_inc
         $error("uart_baud_gen: increment out of range for this CLK_HZ/OVERSAMPLE/ACC_W");
      end
      assign inc_tab[g] = INC[ACC_W-1:0];
   end

   logic [1:0]       rst_sync_q;
   logic             run_ok;
   baud_code_e       baud_q;
   logic             baud_chg_q;
   logic             resync_pend_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             sample_q, sample_d;
   logic [ACC_W:0]   sum;
   logic             baud_diff;
   logic             ph_clear, ph_load;

   assign run_ok    = rst_sync_q[1];
   assign baud_diff = (baud_select != baud_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   // Carry out of the accumulator is the sample strobe; priority enable > baud change > resync > count
   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, inc_tab[baud_q]};
      acc_d    = sum[ACC_W-1:0];
      sample_d = sum[ACC_W];
      ph_clear = 1'b0;
      ph_load  = 1'b0;
      if (!run_ok || !enable) begin
         acc_d    = '0;
         sample_d = 1'b0;
         ph_clear = 1'b1;
      end else if (baud_chg_q) begin
         acc_d    = '0;
         sample_d = 1'b0;
         ph_load  = resync | resync_pend_q;
         ph_clear = ~ph_load;
      end else if (resync) begin
         acc_d    = '0;
         sample_d = 1'b0;
         ph_load  = 1'b1;
      end
   end

   // While the reset synchroniser fills, the rate code is tracked without raising a change
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         baud_q        <= BAUD_300;
         baud_chg_q    <= 1'b0;
         resync_pend_q <= 1'b0;
         acc_q         <= '0;
         sample_q      <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         sample_q <= sample_d;
         baud_q   <= baud_code_e'(baud_select);
         if (!run_ok) begin
            baud_chg_q    <= 1'b0;
            resync_pend_q <= 1'b0;
         end else begin
            baud_chg_q    <= baud_diff;
            resync_pend_q <= resync & enable & baud_diff;
         end
      end
   end

   uart_tick_div #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_tick_div (
      .clk_i     (clk),
      .rst_ni    (reset),
      .clear_i   (ph_clear),
      .load_i    (ph_load),
      .load_val_i(PH_W'(OVERSAMPLE / 2)),
      .step_i    (sample_d),
      .phase_o   (bit_phase),
      .wrap_o    (bit_tick)
   );

   assign sample_ENABLE = sample_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - directed self-checking bench for uart_baud_gen at 50 MHz, x16, 24-bit accumulator
module tb_uart_baud_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] baud_select;
   logic       resync;
   logic       sample_ENABLE;
   logic       bit_tick;
   logic [3:0] bit_phase;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   uart_baud_gen #(
      .CLK_HZ    (50000000),
      .OVERSAMPLE(16),
      .ACC_W     (24)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .baud_select  (baud_select),
      .resync       (resync),
      .sample_ENABLE(sample_ENABLE),
      .bit_tick     (bit_tick),
      .bit_phase    (bit_phase)
   );

   typedef struct {
      logic [2:0] code;
      int         latency;
   } lat_vec_t;

   lat_vec_t vecs [7];

   int e, got, cnt, last, since;
   int n_s, n_t, bad_per, bad_tick;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_sample(input int budget, output int edges);
      edges = 0;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (sample_ENABLE) begin
            edges = i;
            return;
         end
      end
   endtask

   // Called 1 time unit after a rising edge with reset low; releases reset between edges
   task automatic release_and_check(input string tag);
      int ed;
      #2 reset = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         step();
         check({tag, "_hold"}, {sample_ENABLE, bit_tick, bit_phase}, 0);
      end
      wait_sample(100, ed);
      check({tag, "_first_edge"}, ed + 2, 30);
   endtask

   initial begin
      vecs = '{
         '{3'd1, 2605}, '{3'd2, 652}, '{3'd3, 326}, '{3'd4, 163},
         '{3'd5, 82},   '{3'd6, 55},  '{3'd7, 28}
      };

      reset       = 1'b0;
      enable      = 1'b1;
      baud_select = 3'd7;
      resync      = 1'b0;

      repeat (3) step();
      check("reset_state", {sample_ENABLE, bit_tick, bit_phase}, 0);
      release_and_check("por");

      foreach (vecs[i]) begin
         enable      = 1'b0;
         baud_select = vecs[i].code;
         step();
         step();
         check($sformatf("tab%0d_idle", vecs[i].code), {sample_ENABLE, bit_tick, bit_phase}, 0);
         enable = 1'b1;
         wait_sample(3000, e);
         check($sformatf("tab%0d_first", vecs[i].code), e, vecs[i].latency);
      end

      enable      = 1'b0;
      baud_select = 3'd7;
      step();
      step();
      enable   = 1'b1;
      n_s      = 0;
      n_t      = 0;
      bad_per  = 0;
      bad_tick = 0;
      last     = 0;
      since    = 0;
      for (int n = 1; n <= 50000; n++) begin
         step();
         if (sample_ENABLE) begin
            n_s++;
            since++;
            if (last != 0 && (n - last) != 27 && (n - last) != 28) bad_per++;
            last = n;
         end
         if (bit_tick) begin
            n_t++;
            if (!sample_ENABLE || bit_phase != 4'd0 || since != 16) bad_tick++;
            since = 0;
         end
      end
      check("c7_samples", n_s, 1843);
      check("c7_ticks", n_t, 115);
      check("c7_bad_periods", bad_per, 0);
      check("c7_bad_ticks", bad_tick, 0);

      baud_select = 3'd5;
      step();
      step();
      check("sw75_clear", {sample_ENABLE, bit_tick, bit_phase}, 0);
      wait_sample(200, e);
      check("sw75_first", e, 82);

      baud_select = 3'd3;
      repeat (300) step();
      resync = 1'b1;
      step();
      resync = 1'b0;
      check("rs_load", {sample_ENABLE, bit_tick, bit_phase}, 8);
      cnt = 0;
      got = 0;
      for (int i = 0; i < 4000 && got == 0; i++) begin
         step();
         if (sample_ENABLE) cnt++;
         if (bit_tick) got = 1;
      end
      check("rs_samples_to_tick", (got != 0) ? cnt : 0, 8);

      baud_select = 3'd4;
      resync      = 1'b1;
      step();
      resync = 1'b0;
      step();
      check("rsbaud_load", {sample_ENABLE, bit_tick, bit_phase}, 8);
      wait_sample(400, e);
      check("rsbaud_first", e, 163);

      enable = 1'b0;
      resync = 1'b1;
      step();
      check("en_resync", {sample_ENABLE, bit_tick, bit_phase}, 0);
      resync = 1'b0;
      step();
      check("en_hold", {sample_ENABLE, bit_tick, bit_phase}, 0);

      enable      = 1'b1;
      baud_select = 3'd7;
      got         = 0;
      for (int i = 0; i < 2000 && got == 0; i++) begin
         step();
         if (bit_tick) got = 1;
      end
      check("ar_tick_seen", got, 1);
      #2 reset = 1'b0;
      #1;
      check("ar_async_drop", {sample_ENABLE, bit_tick}, 0);
      step();
      step();
      check("ar_reset_state", {sample_ENABLE, bit_tick, bit_phase}, 0);
      release_and_check("ar");

      enable      = 1'b0;
      baud_select = 3'd0;
      step();
      step();
      enable = 1'b1;
      wait_sample(11000, e);
      check("c0_first", e, 10415);
      wait_sample(11000, e);
      check_range("c0_period1", e, 10414, 10415);
      wait_sample(11000, e);
      check_range("c0_period2", e, 10414, 10415);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
